mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined core. Requests are arbitrated, issued to the memory as registered single-cycle commands, and completed with a one-cycle `ready` pulse carrying registered read data. Requesters hold their request until `ready`; the pipeline stalls the requesting stage while its `ready` is low.

---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//
// Groups the fetch-port, data-port and memory-command signals of
// mem_port_arbiter into one bundle.
//
// Modports:
//   master - arbiter view: it samples requests and memory read data, and drives
//            completions plus the registered memory command.
//   slave  - environment view (pipeline stages + memory): the mirror image.
//
// Signals:
//   if_req/if_addr                    fetch read request, held until if_ready
//   if_rdata/if_ready                 fetch completion pulse and instruction word
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be
//                                     data request, held until dm_ready
//   dm_rdata/dm_ready                 data completion pulse and load word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be
//                                     registered single-cycle memory command
//   mem_rdata                         memory read data, MEM_LATENCY cycles after mem_en
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  mem_rdata,
        output if_rdata, if_ready,
        output dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output mem_rdata,
        input  if_rdata, if_ready,
        input  dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency memory between the fetch stage and the
// memory stage. One transaction at a time: the winner's command is registered,
// issued for exactly one cycle, the read word (if any) is captured after
// MEM_LATENCY cycles, and the owner gets a one-cycle ready pulse.
//
// Parameters:
//   MEM_LATENCY  cycles from the mem_en cycle to valid mem_rdata (>= 1)
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.master (fetch port, data port, memory command)
//   busy   high whenever the arbiter is not idle
//
// Build option:
//   MEM_ARB_FAIRNESS_EN  when defined, simultaneous requests alternate based on a
//                        last-grant register; otherwise data always beats fetch.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mem_port_arbiter_if.master        bus,
    output logic                      busy
);

    // Guarded so an illegal latency reports the elaboration error below rather
    // than a zero-width counter.
    localparam int unsigned CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        OwnIf,
        OwnDm
    } owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      resp_q, resp_d;

    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;

    logic             any_req;
    logic             grant_dm;
    logic             grant_store;

    assign any_req = bus.if_req | bus.dm_req;

`ifdef MEM_ARB_FAIRNESS_EN
    owner_e last_q, last_d;

    // On contention the side that did not win last time goes first.
    assign grant_dm = bus.dm_req & (~bus.if_req | (last_q == OwnIf));

    always_comb begin
        last_d = last_q;
        if ((state_q == StIdle) && any_req) begin
            last_d = grant_dm ? OwnDm : OwnIf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OwnIf;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // The data stage holds the older instruction, so it always wins.
    assign grant_dm = bus.dm_req;
`endif

    assign grant_store = grant_dm & bus.dm_we;

    // Next-state and command/response register updates.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        resp_d   = resp_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d  = grant_dm ? OwnDm : OwnIf;
                    we_d     = grant_store;
                    addr_d   = grant_dm ? bus.dm_addr : bus.if_addr;
                    wdata_d  = grant_store ? bus.dm_wdata : 32'h0;
                    be_d     = grant_store ? bus.dm_be : 4'hF;
                    // Stores complete with a zero response word.
                    resp_d   = 32'h0;
                    mem_en_d = 1'b1;
                    mem_we_d = grant_store;
                    state_d  = StIssue;
                end
            end

            StIssue: begin
                if (we_q) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = CNT_W'(MEM_LATENCY);
                    state_d = StWait;
                end
            end

            StWait: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Count of 1 marks the cycle in which mem_rdata is valid.
                if (cnt_q == CNT_W'(1)) begin
                    resp_d  = bus.mem_rdata;
                    state_d = StResp;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= OwnIf;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            resp_q   <= 32'h0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    logic if_done;
    logic dm_done;

    assign if_done = (state_q == StResp) & (owner_q == OwnIf);
    assign dm_done = (state_q == StResp) & (owner_q == OwnDm);

    assign busy          = (state_q != StIdle);
    assign bus.if_ready  = if_done;
    assign bus.dm_ready  = dm_done;
    // Read data is only presented alongside its ready pulse.
    assign bus.if_rdata  = if_done ? resp_q : 32'h0;
    assign bus.dm_rdata  = dm_done ? resp_q : 32'h0;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned LAT_A      = 1;
    localparam int unsigned LAT_B      = 3;
    localparam int          RND_CYCLES = 3000;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy_a;
    logic busy_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rnd_trace [RND_CYCLES + 8];

    mem_port_arbiter_if bus_a ();
    mem_port_arbiter_if bus_b ();

    mem_port_arbiter #(.MEM_LATENCY(LAT_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a),
        .busy  (busy_a)
    );

    mem_port_arbiter #(.MEM_LATENCY(LAT_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b),
        .busy  (busy_b)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus_a.if_req = 1'b0; bus_a.if_addr = 32'h0;
        bus_a.dm_req = 1'b0; bus_a.dm_we = 1'b0; bus_a.dm_addr = 32'h0;
        bus_a.dm_wdata = 32'h0; bus_a.dm_be = 4'h0; bus_a.mem_rdata = 32'h0;
        bus_b.if_req = 1'b0; bus_b.if_addr = 32'h0;
        bus_b.dm_req = 1'b0; bus_b.dm_we = 1'b0; bus_b.dm_addr = 32'h0;
        bus_b.dm_wdata = 32'h0; bus_b.dm_be = 4'h0; bus_b.mem_rdata = 32'h0;
    endtask

    // Leaves the caller at a falling edge with reset just released (cycle 0).
    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        bus_a.dm_req = 1'b1;
        bus_b.if_req = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_a, bus_a.mem_en, bus_a.mem_we, bus_a.if_ready, bus_a.dm_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl_a got=%b exp=00000",
                     {busy_a, bus_a.mem_en, bus_a.mem_we, bus_a.if_ready, bus_a.dm_ready});
        end
        n_cmp++;
        if ({busy_b, bus_b.mem_en, bus_b.mem_we, bus_b.if_ready, bus_b.dm_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl_b got=%b exp=00000",
                     {busy_b, bus_b.mem_en, bus_b.mem_we, bus_b.if_ready, bus_b.dm_ready});
        end
        n_cmp++;
        if (bus_a.mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_addr got=%h exp=0", bus_a.mem_addr);
        end
        n_cmp++;
        if (bus_a.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wdata got=%h exp=0", bus_a.mem_wdata);
        end
        n_cmp++;
        if (bus_a.mem_be !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_be got=%h exp=0", bus_a.mem_be);
        end
        n_cmp++;
        if ({bus_a.if_rdata, bus_a.dm_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_rdata got=%h exp=0", {bus_a.if_rdata, bus_a.dm_rdata});
        end
        idle_inputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_a, busy_b, bus_a.mem_en, bus_b.mem_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_after got=%b exp=0000",
                     {busy_a, busy_b, bus_a.mem_en, bus_b.mem_en});
        end
    endtask

    task automatic test_fetch();
        do_reset();
        bus_a.if_req    = 1'b1;
        bus_a.if_addr   = 32'h100;
        bus_a.mem_rdata = $urandom;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_a.mem_en !== (c == 1)) begin
                n_fail++;
                $display("FAIL fetch_mem_en c=%0d got=%b exp=%b", c, bus_a.mem_en, c == 1);
            end
            if (c == 1) begin
                n_cmp++;
                if ({bus_a.mem_addr, bus_a.mem_be, bus_a.mem_we} !== {32'h100, 4'hF, 1'b0}) begin
                    n_fail++;
                    $display("FAIL fetch_cmd got=%h/%h/%b exp=00000100/f/0",
                             bus_a.mem_addr, bus_a.mem_be, bus_a.mem_we);
                end
            end
            n_cmp++;
            if ({bus_a.if_ready, bus_a.dm_ready} !== {c == 3, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_ready c=%0d got=%b%b exp=%b0", c,
                         bus_a.if_ready, bus_a.dm_ready, c == 3);
            end
            if (c == 3) begin
                n_cmp++;
                if (bus_a.if_rdata !== 32'h00500093) begin
                    n_fail++;
                    $display("FAIL fetch_rdata got=%h exp=00500093", bus_a.if_rdata);
                end
                bus_a.if_req = 1'b0;
            end
            n_cmp++;
            if (busy_a !== (c <= 3)) begin
                n_fail++;
                $display("FAIL fetch_busy c=%0d got=%b exp=%b", c, busy_a, c <= 3);
            end
            bus_a.mem_rdata = (c == 2) ? 32'h00500093 : $urandom;
        end
    endtask

    task automatic test_store();
        do_reset();
        bus_a.dm_req   = 1'b1;
        bus_a.dm_we    = 1'b1;
        bus_a.dm_addr  = 32'h2000;
        bus_a.dm_wdata = 32'hDEADBEEF;
        bus_a.dm_be    = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_a.mem_en, bus_a.mem_we} !== {c == 1, c == 1}) begin
                n_fail++;
                $display("FAIL store_en_we c=%0d got=%b%b exp=%b%b", c,
                         bus_a.mem_en, bus_a.mem_we, c == 1, c == 1);
            end
            if (c == 1) begin
                n_cmp++;
                if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_be} !==
                    {32'h2000, 32'hDEADBEEF, 4'b0011}) begin
                    n_fail++;
                    $display("FAIL store_cmd got=%h/%h/%h exp=00002000/deadbeef/3",
                             bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_be);
                end
            end
            n_cmp++;
            if ({bus_a.dm_ready, bus_a.if_ready} !== {c == 2, 1'b0}) begin
                n_fail++;
                $display("FAIL store_ready c=%0d got=%b%b exp=%b0", c,
                         bus_a.dm_ready, bus_a.if_ready, c == 2);
            end
            if (c == 2) begin
                n_cmp++;
                if (bus_a.dm_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL store_rdata got=%h exp=0", bus_a.dm_rdata);
                end
                bus_a.dm_req = 1'b0;
            end
            n_cmp++;
            if (busy_a !== (c <= 2)) begin
                n_fail++;
                $display("FAIL store_busy c=%0d got=%b exp=%b", c, busy_a, c <= 2);
            end
        end
    endtask

    // Both sides hold loads; ready pulses every 3+L cycles in policy order.
    task automatic test_priority();
        int got;
        bit exp_dm;
        logic [31:0] rd;
        do_reset();
        got = 0;
        bus_a.if_req    = 1'b1;
        bus_a.if_addr   = 32'h100;
        bus_a.dm_req    = 1'b1;
        bus_a.dm_we     = 1'b0;
        bus_a.dm_addr   = 32'h3000;
        bus_a.mem_rdata = 32'hA000_0000;
        for (int c = 1; c <= 40 && got < 4; c++) begin
            @(negedge clk);
            if (bus_a.if_ready || bus_a.dm_ready) begin
                exp_dm = (got == 0) || (got == 2) || (got == 1 && !FAIR);
                n_cmp++;
                if ({bus_a.dm_ready, bus_a.if_ready} !== {exp_dm, !exp_dm}) begin
                    n_fail++;
                    $display("FAIL prio_owner n=%0d got dm/if=%b%b exp=%b%b", got,
                             bus_a.dm_ready, bus_a.if_ready, exp_dm, !exp_dm);
                end
                n_cmp++;
                if (c != 3 + 4 * got) begin
                    n_fail++;
                    $display("FAIL prio_cycle n=%0d got=%0d exp=%0d", got, c, 3 + 4 * got);
                end
                rd = bus_a.dm_ready ? bus_a.dm_rdata : bus_a.if_rdata;
                n_cmp++;
                if (rd !== 32'hA000_0000 + 32'(c - 1)) begin
                    n_fail++;
                    $display("FAIL prio_rdata n=%0d got=%h exp=%h", got, rd,
                             32'hA000_0000 + 32'(c - 1));
                end
                got++;
                if (got == 3) bus_a.dm_req = 1'b0;
                if (got == 4) bus_a.if_req = 1'b0;
            end
            bus_a.mem_rdata = 32'hA000_0000 + 32'(c);
        end
        n_cmp++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL prio_timeout got=%0d exp=4 completions", got);
        end
        idle_inputs();
    endtask

    task automatic test_latency();
        logic [31:0] tr [8];
        do_reset();
        bus_b.dm_req    = 1'b1;
        bus_b.dm_we     = 1'b0;
        bus_b.dm_addr   = 32'h40;
        bus_b.dm_wdata  = 32'h1234_5678;
        tr[0]           = $urandom;
        bus_b.mem_rdata = tr[0];
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_b.mem_en, bus_b.mem_we} !== {c == 1, 1'b0}) begin
                n_fail++;
                $display("FAIL lat_mem_en c=%0d got=%b%b exp=%b0", c,
                         bus_b.mem_en, bus_b.mem_we, c == 1);
            end
            if (c == 1) begin
                n_cmp++;
                if ({bus_b.mem_addr, bus_b.mem_be} !== {32'h40, 4'hF}) begin
                    n_fail++;
                    $display("FAIL lat_cmd got=%h/%h exp=00000040/f",
                             bus_b.mem_addr, bus_b.mem_be);
                end
            end
            n_cmp++;
            if ({bus_b.dm_ready, bus_b.if_ready} !== {c == 5, 1'b0}) begin
                n_fail++;
                $display("FAIL lat_ready c=%0d got=%b%b exp=%b0", c,
                         bus_b.dm_ready, bus_b.if_ready, c == 5);
            end
            if (c == 5) begin
                n_cmp++;
                if (bus_b.dm_rdata !== tr[4]) begin
                    n_fail++;
                    $display("FAIL lat_rdata got=%h exp=%h", bus_b.dm_rdata, tr[4]);
                end
                bus_b.dm_req = 1'b0;
            end
            n_cmp++;
            if (busy_b !== (c <= 5)) begin
                n_fail++;
                $display("FAIL lat_busy c=%0d got=%b exp=%b", c, busy_b, c <= 5);
            end
            tr[c]           = $urandom;
            bus_b.mem_rdata = tr[c];
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] tr [8];
        do_reset();
        bus_b.if_req  = 1'b1;
        bus_b.if_addr = 32'h80;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_pre_busy got=%b exp=1", busy_b);
        end
        rst_n = 1'b0;
        bus_b.if_req = 1'b0;
        #1;
        n_cmp++;
        if ({busy_b, bus_b.mem_en, bus_b.mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstw_async got=%b exp=000", {busy_b, bus_b.mem_en, bus_b.mem_we});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_b, bus_b.if_ready, bus_b.dm_ready} !== 3'b000) begin
                n_fail++;
                $display("FAIL rstw_quiet c=%0d got=%b exp=000", c,
                         {busy_b, bus_b.if_ready, bus_b.dm_ready});
            end
        end
        bus_b.if_req    = 1'b1;
        bus_b.if_addr   = 32'h84;
        tr[0]           = $urandom;
        bus_b.mem_rdata = tr[0];
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_b.if_ready !== (c == 5)) begin
                n_fail++;
                $display("FAIL rstw_ready c=%0d got=%b exp=%b", c, bus_b.if_ready, c == 5);
            end
            if (c == 5) begin
                n_cmp++;
                if (bus_b.if_rdata !== tr[4]) begin
                    n_fail++;
                    $display("FAIL rstw_rdata got=%h exp=%h", bus_b.if_rdata, tr[4]);
                end
                bus_b.if_req = 1'b0;
            end
            tr[c]           = $urandom;
            bus_b.mem_rdata = tr[c];
        end
    endtask

    // Random traffic on the L=3 instance against a transaction timeline:
    // grant at t0, command at t0+1, data sampled at t0+1+L, ready at t0+2(+L).
    task automatic test_random();
        bit          if_p, dm_p, dwe, act, own_dm, twe, last_dm;
        bit          e_busy, e_en, e_ifr, e_dmr;
        logic [31:0] ia, da, dw, taddr, twdata, tdata, rd;
        logic [3:0]  db, tbe;
        int          t0, r;
        do_reset();
        if_p = 0; dm_p = 0; act = 0; last_dm = 0; own_dm = 0; twe = 0;
        ia = 0; da = 0; dw = 0; db = 0; dwe = 0;
        taddr = 0; twdata = 0; tbe = 0; t0 = -100;
        for (int c = 0; c < RND_CYCLES; c++) begin
            if (c != 0) @(negedge clk);
            r      = t0 + 2 + (twe ? 0 : int'(LAT_B));
            e_busy = act && c >= t0 + 1 && c <= r;
            e_en   = act && c == t0 + 1;
            e_ifr  = act && c == r && !own_dm;
            e_dmr  = act && c == r && own_dm;
            n_cmp++;
            if (busy_b !== e_busy) begin
                n_fail++;
                $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_b, e_busy);
            end
            n_cmp++;
            if ({bus_b.mem_en, bus_b.mem_we} !== {e_en, e_en && twe}) begin
                n_fail++;
                $display("FAIL rnd_en_we c=%0d got=%b%b exp=%b%b", c,
                         bus_b.mem_en, bus_b.mem_we, e_en, e_en && twe);
            end
            n_cmp++;
            if ({bus_b.if_ready, bus_b.dm_ready} !== {e_ifr, e_dmr}) begin
                n_fail++;
                $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c,
                         bus_b.if_ready, bus_b.dm_ready, e_ifr, e_dmr);
            end
            if (e_en) begin
                n_cmp++;
                if ({bus_b.mem_addr, bus_b.mem_be} !== {taddr, tbe}) begin
                    n_fail++;
                    $display("FAIL rnd_cmd c=%0d got=%h/%h exp=%h/%h", c,
                             bus_b.mem_addr, bus_b.mem_be, taddr, tbe);
                end
                if (twe) begin
                    n_cmp++;
                    if (bus_b.mem_wdata !== twdata) begin
                        n_fail++;
                        $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c,
                                 bus_b.mem_wdata, twdata);
                    end
                end
            end
            if (e_ifr || e_dmr) begin
                tdata = twe ? 32'h0 : rnd_trace[t0 + 1 + int'(LAT_B)];
                rd    = e_dmr ? bus_b.dm_rdata : bus_b.if_rdata;
                n_cmp++;
                if (rd !== tdata) begin
                    n_fail++;
                    $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rd, tdata);
                end
            end
            // Requesters: on completion either keep going with a new request or drop.
            if (e_ifr) begin
                if_p = 1'($urandom);
                ia   = $urandom & 32'hFFFF_FFFC;
            end
            if (e_dmr) begin
                dm_p = 1'($urandom);
                da   = $urandom & 32'hFFFF_FFFC;
                dw   = $urandom;
                db   = 4'($urandom);
                dwe  = 1'($urandom);
            end
            if (!if_p && ($urandom_range(0, 3) == 0)) begin
                if_p = 1'b1;
                ia   = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_p && ($urandom_range(0, 3) == 0)) begin
                dm_p = 1'b1;
                da   = $urandom & 32'hFFFF_FFFC;
                dw   = $urandom;
                db   = 4'($urandom);
                dwe  = 1'($urandom);
            end
            rnd_trace[c]    = $urandom;
            bus_b.mem_rdata = rnd_trace[c];
            bus_b.if_req    = if_p;
            bus_b.if_addr   = ia;
            bus_b.dm_req    = dm_p;
            bus_b.dm_we     = dwe;
            bus_b.dm_addr   = da;
            bus_b.dm_wdata  = dw;
            bus_b.dm_be     = db;
            if (act && c == r) begin
                act = 1'b0;
            end else if (!act && (if_p || dm_p)) begin
                own_dm  = (if_p && dm_p) ? (FAIR ? !last_dm : 1'b1) : dm_p;
                last_dm = own_dm;
                act     = 1'b1;
                t0      = c;
                twe     = own_dm && dwe;
                taddr   = own_dm ? da : ia;
                twdata  = dw;
                tbe     = twe ? db : 4'hF;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_latency();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
